// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings and default frame geometry for the UART drain path.
package uart_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_DATA_BITS    = 8;
  localparam int FRAME_BITS       = DEF_DATA_BITS + 2;
endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read-side handshake plus serial line and frame status.
interface uart_tx_fifo_drain_if import uart_pkg::*; #(parameter int DATA_BITS = DEF_DATA_BITS);
  logic                 tx_en;
  logic                 empty;
  logic [DATA_BITS-1:0] pop_data;
  logic                 pop;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;
  modport master(output tx_en, empty, pop_data, input pop, tx, busy, tx_done);
  modport slave(input tx_en, empty, pop_data, output pop, tx, busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every CLKS_PER_BIT clocks, restarted by clr.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == W'(CLKS_PER_BIT - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops show-ahead FIFO bytes and serializes each as an 8N1 frame.
module uart_tx_fifo_drain import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic clk,
  input  logic rst,
  uart_tx_fifo_drain_if.slave bus
);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d, pop_q, pop_d, busy_q, busy_d, tx_done_q, tx_done_d;
  logic                 clr, tick;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick)
  );
  // empty is only looked at in IDLE, so the FIFO's post-pop flag latency never matters
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop_d     = 1'b0;
    tx_done_d = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: if (bus.tx_en && !bus.empty) begin
        shift_d = bus.pop_data;
        state_d = START;
        tx_d    = 1'b0;
        pop_d   = 1'b1;
        busy_d  = 1'b1;
        clr     = 1'b1;
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = shift_q[0];
        bit_d   = '0;
      end
      DATA: if (tick) begin
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_d[0];
          bit_d   = bit_q + 1'b1;
        end
      end
      default: if (tick) begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        tx_done_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  assign bus.tx      = tx_q;
  assign bus.pop     = pop_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: FIFO model feeds bytes; a frame monitor decodes tx against a scoreboard.
module tb_uart_tx_fifo_drain;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_drain_if #(.DATA_BITS(8)) bus();
  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst_n), .bus(bus)
  );
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int pop_t[$];
  int n_chk = 0, n_fail = 0, npops = 0, ndone = 0, cyc = 0;
  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask
  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    exp_q.push_back(b);
  endtask
  task automatic wait_pop(input int n0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (npops > n0) return;
    end
    chk(1'b0, "pop_timeout", npops, n0 + 1);
  endtask
  task automatic wait_done(input int t);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (ndone >= t) return;
    end
    chk(1'b0, "done_timeout", ndone, t);
  endtask
  always @(posedge clk) cyc++;
  // show-ahead FIFO: head advances on the edge that ends the pop cycle
  initial begin
    logic p;
    bus.tx_en = 1'b0;
    bus.empty = 1'b1;
    bus.pop_data = 8'h00;
    forever begin
      @(negedge clk);
      p = bus.pop;
      if (p) begin
        npops++;
        pop_t.push_back(cyc);
        chk(fifo.size() > 0, "pop_nonempty", fifo.size(), 1);
      end
      @(posedge clk);
      #1;
      if (p && fifo.size() > 0) fifo.delete(0);
      bus.empty = fifo.size() == 0;
      bus.pop_data = fifo.size() > 0 ? fifo[0] : 8'h00;
    end
  end
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n)
        chk(bus.tx && !bus.pop && !bus.busy && !bus.tx_done, "reset_outputs",
            int'({bus.tx, bus.pop, bus.busy, bus.tx_done}), 8);
      if (bus.pop) begin
        chk(!prev, "pop_width", int'(prev), 0);
        chk(!bus.tx_done, "pop_vs_done", int'(bus.tx_done), 0);
      end
      if (bus.tx_done) ndone++;
      prev = bus.pop;
    end
  end
  initial begin
    logic [7:0] e, rx;
    logic b;
    int bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (rst_n && !bus.tx) begin
        chk(exp_q.size() > 0, "frame_expected", exp_q.size(), 1);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
        bad = 0;
        abort = 1'b0;
        rx = 8'h00;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
          b = c < CPB ? 1'b0 : c >= 9 * CPB ? 1'b1 : e[(c - CPB) / CPB];
          if (bus.tx !== b || !bus.busy || bus.tx_done) bad++;
          if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) rx[(c - CPB) / CPB] = bus.tx;
        end
        if (!abort) begin
          chk(rx == e, "frame_data", int'(rx), int'(e));
          chk(bad == 0, "frame_timing", bad, 0);
          @(negedge clk);
          chk(rst_n && bus.tx && !bus.busy && bus.tx_done, "frame_end",
              int'({bus.tx, bus.busy, bus.tx_done}), 5);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1);
  end
  initial begin
    int bad, n0;
    push(8'hFF);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk(!bus.pop, "no_pop_tx_en0", int'(bus.pop), 0);
    end
    bus.tx_en = 1'b1;
    @(negedge clk);
    chk(bus.pop, "pop_on_enable", int'(bus.pop), 1);
    wait_done(1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.pop || !bus.tx) bad++;
    end
    chk(bad == 0, "idle_empty", bad, 0);
    push(8'hA5);
    wait_done(2);
    push(8'h00);
    push(8'hFF);
    wait_done(4);
    chk(pop_t[$] - pop_t[$-1] == 41, "b2b_pop_gap", pop_t[$] - pop_t[$-1], 41);
    n0 = npops;
    push(8'h3C);
    push(8'h77);
    wait_pop(n0);
    repeat (18) @(negedge clk);
    bus.tx_en = 1'b0;
    wait_done(5);
    n0 = npops;
    repeat (50) @(negedge clk);
    chk(npops == n0, "no_pop_after_drop", npops, n0);
    chk(fifo.size() == 1, "fifo_left", fifo.size(), 1);
    bus.tx_en = 1'b1;
    wait_pop(n0);
    repeat (26) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk(bus.tx && !bus.busy, "async_reset", int'({bus.tx, bus.busy}), 2);
    push(8'h5A);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_done(6);
    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    chk(npops == 7, "total_pops", npops, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the FIFO's read side.
- Watches `empty`, pops one byte at a time via `pop`/`pop_data`, and serializes each byte as an 8N1 UART frame on `tx`.
- Single clock domain: runs on the FIFO read clock. Completes the push -> FIFO -> serial-out path.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal values are >= 2; elaboration error otherwise.
- DATA_BITS, 8: payload bits per frame, LSB first. Must match FIFO data width.

Ports:
- clk  input  1  block clock; same clock as the FIFO read port.
- rst  input  1  asynchronous, active-low reset: 0 = reset asserted; deassertion is synchronous to clk externally.
- tx_en  input  1  1 = allowed to start new frames. Sampled only in IDLE; never aborts a frame.
- empty  input  1  FIFO empty flag.
- pop_data  input  DATA_BITS  FIFO head word. Show-ahead: valid whenever empty=0.
- pop  output  1  one-cycle pop strobe to FIFO; registered.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  1 while a frame is in progress (START..STOP).
- tx_done  output  1  one-cycle pulse after the stop bit completes; registered.

Behaviour:
- Reset (rst=0, async):
  - Outputs: tx=1, pop=0, busy=0, tx_done=0.
  - State: state=IDLE, bit counter=0, baud counter=0, shift register=0.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - If tx_en=1 and empty=0 at edge k:
    - shift register <= pop_data; state <= START; tx <= 0; pop <= 1; busy <= 1; baud counter <= 0.
  - pop is high exactly for cycle k..k+1. The FIFO advances at edge k+1.
  - Otherwise remain in IDLE with pop=0 and tx=1.
- START: tx=0 for CLKS_PER_BIT cycles. Then state <= DATA, tx <= shift[0], bit counter <= 0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, then shift right and put the next LSB on tx.
  - After bit DATA_BITS-1 completes: state <= STOP, tx <= 1.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end: state <= IDLE, busy <= 0, tx_done <= 1 for one cycle.
- Frame timing:
  - Frame = (DATA_BITS+2)*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the return to IDLE.
  - The minimum gap between frames is 1 clk, the IDLE decision cycle. Back-to-back frames are therefore (DATA_BITS+2)*CLKS_PER_BIT+1 cycles apart.
- Baud counter:
  - Width = clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1.
  - The bit-end tick fires at CLKS_PER_BIT-1, and the counter wraps to 0 on that tick.
- Bit counter: width = clog2(DATA_BITS); reaching DATA_BITS-1 marks the last data bit.
- Boundary conditions:
  - pop is never asserted while empty=0 is stale. After a pop, `empty` is ignored until the next IDLE cycle, so the FIFO latency from a rd edge to the empty update is always absorbed.
  - At most one pop per frame; pop is never asserted outside IDLE->START.
  - tx_en dropping mid-frame: the current frame completes normally; no further pops occur.
  - empty rising mid-frame: no effect on the current frame.
  - Reset mid-frame: the line returns to 1 immediately. The popped byte is discarded; no re-pop.
  - tx_done and the next pop never coincide; they are at least 1 cycle apart.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP) as 2-bit encoded constants.
  - Default CLKS_PER_BIT and DATA_BITS constants.
  - Frame-length helper constant (DATA_BITS+2).
- Sub-module uart_baud_tick:
  - Ports: clk, rst, clr, tick.
  - Parameterized counter; produces a one-cycle tick every CLKS_PER_BIT cycles and restarts on clr.
  - Instantiated once; the FSM asserts clr on the IDLE->START transition.

Test Plan:
- Reset: rst=0 with pop_data=0xFF and empty=0 -> tx=1, pop=0, busy=0, tx_done=0 throughout reset. No pop in the first cycle after release unless tx_en=1.
- Single byte (CLKS_PER_BIT=4): empty 1->0 with pop_data=0xA5, tx_en=1.
  - pop high exactly 1 cycle.
  - tx shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - tx_done pulses at cycle 40 after the first 0. busy is high for 40 cycles.
- Back-to-back: FIFO holds 0x00 then 0xFF.
  - Two pops exactly 41 cycles apart.
  - Frame 1 data bits all 0; frame 2 data bits all 1.
  - Stop bit of frame 1 and start bit of frame 2 separated by one idle-high cycle.
- Empty/gating:
  - empty=1 for 100 cycles -> pop stays 0, tx stays 1.
  - empty=0 with tx_en=0 -> no pop. Raising tx_en -> pop on the next edge.
- tx_en drop mid-frame: deassert tx_en during DATA bit 3 with FIFO non-empty -> frame completes with correct bits and tx_done pulses. No further pop.
- Async reset mid-frame: rst=0 during DATA bit 5 -> tx=1 and busy=0 within the same cycle (no clock edge needed). After release, the next FIFO byte is sent as a complete fresh frame.
